// File: rtl/bm_update_ctrl_if.sv
// Update-request channel of the block-match CAM update engine.
// The requester drives the request fields; the engine returns ready and the done/err pulses.
interface bm_update_ctrl_if #(
  parameter int unsigned IDX_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [IDX_W-1:0] req_idx;
  logic [23:0]      req_key;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_op, req_idx, req_key,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_op, req_idx, req_key,
    output req_ready, done, err
  );
endinterface

// File: rtl/bm_update_ctrl.sv
// Update engine and address mux for a LUTRAM CAM bank of 24-bit block-match columns.
// A write or delete sweeps all 64 addresses of one column while searches are held off.
module bm_update_ctrl #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  bm_update_ctrl_if.slave    req,
  input  logic [23:0]        srch_key,
  output logic               srch_ready,
  output logic [ENTRIES-1:0] bm_we,
  output logic [5:0]         bm_addra,
  output logic [5:0]         bm_addrb,
  output logic [5:0]         bm_addrc,
  output logic [5:0]         bm_addrd,
  output logic [3:0]         bm_di
);
  localparam int unsigned SL_W     = 6;
  localparam int unsigned N_SLICES = 4;
  localparam logic [SL_W-1:0] LAST_ADDR = SL_W'(63);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic [SL_W-1:0]  cnt;
  logic             op_q;
  logic [IDX_W-1:0] idx_q;
  logic [23:0]      key_q;
  logic             done_q;
  logic             err_q;
  logic             in_range;
  logic             sweeping;

  assign in_range = (32'(idx_q) < ENTRIES);
  assign sweeping = (state == SWEEP);

  // Sequencer: latch request, sweep 64 addresses, then one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= 1'b0;
      idx_q  <= '0;
      key_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            op_q  <= req.req_op;
            idx_q <= req.req_idx;
            key_q <= req.req_key;
            cnt   <= '0;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          cnt <= cnt + SL_W'(1);
          if (cnt == LAST_ADDR) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= !in_range;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req.req_ready = (state == IDLE);
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign srch_ready    = (state == IDLE);

  // Slice-d port is shared: sweep counter during update, search key otherwise.
  assign bm_addra = srch_key[5:0];
  assign bm_addrb = srch_key[11:6];
  assign bm_addrc = srch_key[17:12];
  assign bm_addrd = sweeping ? cnt : srch_key[23:18];

  assign bm_we = (sweeping && in_range) ? (ENTRIES'(1) << idx_q) : '0;

  // One-hot bitmap: a slice bit is set only at the address equal to its key slice.
  always_comb begin
    bm_di = '0;
    for (int i = 0; i < int'(N_SLICES); i++) begin
      if (sweeping && !op_q && (cnt == key_q[SL_W*i +: SL_W])) bm_di[i] = 1'b1;
    end
  end
endmodule
